// File: rtl/axi_pack_pkg.sv
// Shared types and default widths for the AXI pack SSR address path.
// Overflow checking in axi_pack_addr_gen is enabled by defining AXI_PACK_AG_OVF_CHK_EN.
package axi_pack_pkg;

  localparam int unsigned DefAddrWidth        = 48;
  localparam int unsigned DefStrideWidth      = 8;
  localparam int unsigned DefNestLenWidth     = 6;
  localparam int unsigned DefNestStrideWidth  = 6;
  localparam int unsigned DefIndexWidth       = 32;
  localparam int unsigned DefIndexOffsetWidth = 17;

  typedef enum logic {
    MODE_AFFINE,
    MODE_INDIRECT
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AFFINE,
    ST_INDIRECT
  } state_e;

  typedef struct packed {
    logic [DefStrideWidth-1:0]     stride;
    logic [DefNestLenWidth-1:0]    nest_len;
    logic [DefNestStrideWidth-1:0] nest_stride;
  } affine_t;

  typedef struct packed {
    logic [2:0]                     index_size;
    logic [DefIndexOffsetWidth-1:0] index_offset;
  } indirect_t;

  typedef struct packed {
    logic      indirect;
    affine_t   affine;
    indirect_t ind;
  } ssr_user_t;

endpackage

// File: rtl/axi_pack_affine_cnt.sv
// Two-level nested element counter with row-base and element-address accumulators.
// Exposes the next address/last flag; carry_o exists only with AXI_PACK_AG_OVF_CHK_EN.
module axi_pack_affine_cnt #(
  parameter int unsigned AddrWidth    = 48,
  parameter int unsigned LenWidth     = 8,
  parameter int unsigned NestLenWidth = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic                    advance_i,
  input  logic [AddrWidth-1:0]    base_i,
  input  logic [AddrWidth-1:0]    stride_i,
  input  logic [AddrWidth-1:0]    nest_stride_i,
  input  logic [LenWidth-1:0]     len_i,
  input  logic [NestLenWidth-1:0] nest_len_i,
  output logic [AddrWidth-1:0]    next_addr_o,
  output logic                    next_last_o
`ifdef AXI_PACK_AG_OVF_CHK_EN
  ,
  output logic                    carry_o
`endif
);

`ifdef AXI_PACK_AG_OVF_CHK_EN
  localparam int unsigned SumW = AddrWidth + 1;
`else
  localparam int unsigned SumW = AddrWidth;
`endif

  logic [LenWidth-1:0]     r_i;
  logic [NestLenWidth-1:0] r_j;
  logic [AddrWidth-1:0]    r_row_base;
  logic [AddrWidth-1:0]    r_addr;

  logic                    w_row_wrap;
  logic [LenWidth-1:0]     w_i_inc;
  logic [NestLenWidth-1:0] w_j_inc;
  logic [SumW-1:0]         w_row_sum;
  logic [SumW-1:0]         w_elem_sum;

  assign w_row_wrap = (r_i == len_i);
  assign w_i_inc    = r_i + LenWidth'(1);
  assign w_j_inc    = r_j + NestLenWidth'(1);
  assign w_row_sum  = SumW'(r_row_base) + SumW'(nest_stride_i);
  assign w_elem_sum = SumW'(r_addr) + SumW'(stride_i);

  assign next_addr_o = w_row_wrap ? w_row_sum[AddrWidth-1:0] : w_elem_sum[AddrWidth-1:0];
  assign next_last_o = w_row_wrap ? ((len_i == '0) && (w_j_inc == nest_len_i))
                                  : ((w_i_inc == len_i) && (r_j == nest_len_i));
`ifdef AXI_PACK_AG_OVF_CHK_EN
  assign carry_o = w_row_wrap ? w_row_sum[AddrWidth] : w_elem_sum[AddrWidth];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_i        <= '0;
      r_j        <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
    end else if (load_i) begin
      r_i        <= '0;
      r_j        <= '0;
      r_row_base <= base_i;
      r_addr     <= base_i;
    end else if (advance_i) begin
      if (w_row_wrap) begin
        r_i        <= '0;
        r_j        <= w_j_inc;
        r_row_base <= w_row_sum[AddrWidth-1:0];
        r_addr     <= w_row_sum[AddrWidth-1:0];
      end else begin
        r_i    <= w_i_inc;
        r_addr <= w_elem_sum[AddrWidth-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_pack_addr_gen.sv
// Element-address generator for packed AXI streams: affine (two-level nest) or indirect.
// Define AXI_PACK_AG_OVF_CHK_EN to add the sticky address-overflow flag err_o.
module axi_pack_addr_gen
  import axi_pack_pkg::*;
#(
  parameter int unsigned AddrWidth        = DefAddrWidth,
  parameter int unsigned StrideWidth      = DefStrideWidth,
  parameter int unsigned NestLenWidth     = DefNestLenWidth,
  parameter int unsigned NestStrideWidth  = DefNestStrideWidth,
  parameter int unsigned IndexWidth       = DefIndexWidth,
  parameter int unsigned IndexOffsetWidth = DefIndexOffsetWidth
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [AddrWidth-1:0]        req_addr_i,
  input  logic [1:0]                  req_size_i,
  input  logic [7:0]                  req_len_i,
  input  logic                        req_indirect_i,
  input  logic [StrideWidth-1:0]      req_stride_i,
  input  logic [NestLenWidth-1:0]     req_nest_len_i,
  input  logic [NestStrideWidth-1:0]  req_nest_stride_i,
  input  logic [2:0]                  req_index_size_i,
  input  logic [IndexOffsetWidth-1:0] req_index_offset_i,
  input  logic                        idx_valid_i,
  output logic                        idx_ready_o,
  input  logic [IndexWidth-1:0]       idx_data_i,
  output logic                        addr_valid_o,
  input  logic                        addr_ready_i,
  output logic [AddrWidth-1:0]        addr_o,
  output logic                        addr_last_o,
  output logic                        busy_o
`ifdef AXI_PACK_AG_OVF_CHK_EN
  ,
  output logic                        err_o
`endif
);

`ifdef AXI_PACK_AG_OVF_CHK_EN
  localparam int unsigned SumW = AddrWidth + 1;
`else
  localparam int unsigned SumW = AddrWidth;
`endif

  function automatic logic [IndexWidth-1:0] mask_index(input logic [IndexWidth-1:0] data,
                                                       input logic [2:0]            size);
    logic [IndexWidth-1:0] m;
    for (int unsigned b = 0; b < IndexWidth; b++) m[b] = data[b] & (b < (32'd8 << size));
    return m;
  endfunction

  state_e                  r_state;
  logic                    r_req_ready;
  logic                    r_addr_valid;
  logic [AddrWidth-1:0]    r_addr;
  logic                    r_last;
  logic [7:0]              r_len;
  logic [NestLenWidth-1:0] r_nest_len;
  logic [AddrWidth-1:0]    r_stride_b;
  logic [AddrWidth-1:0]    r_nest_stride_b;
  logic [1:0]              r_size;
  logic [2:0]              r_idx_size;
  logic [AddrWidth-1:0]    r_ind_base;
  logic [8:0]              r_remaining;

  mode_e                   w_req_mode;
  logic                    w_addr_fire;
  logic                    w_idx_ready;
  logic                    w_idx_fire;
  logic                    w_cnt_advance;
  logic [AddrWidth-1:0]    w_cnt_next_addr;
  logic                    w_cnt_next_last;
  logic [AddrWidth-1:0]    w_idx_shift;
  logic [SumW-1:0]         w_ind_base_sum;
  logic [SumW-1:0]         w_ind_sum;

  assign w_req_mode     = req_indirect_i ? MODE_INDIRECT : MODE_AFFINE;
  assign w_addr_fire    = r_addr_valid && addr_ready_i;
  assign w_idx_ready    = (r_state == ST_INDIRECT) && (r_remaining != '0) &&
                          (!r_addr_valid || addr_ready_i);
  assign w_idx_fire     = idx_valid_i && w_idx_ready;
  assign w_cnt_advance  = (r_state == ST_AFFINE) && w_addr_fire && !r_last;
  assign w_idx_shift    = AddrWidth'(mask_index(idx_data_i, r_idx_size)) << r_size;
  assign w_ind_base_sum = SumW'(req_addr_i) + SumW'(req_index_offset_i);
  assign w_ind_sum      = SumW'(r_ind_base) + SumW'(w_idx_shift);

`ifdef AXI_PACK_AG_OVF_CHK_EN
  logic w_cnt_carry;
  logic r_err;
  assign err_o = r_err;
`endif

  axi_pack_affine_cnt #(
    .AddrWidth    (AddrWidth),
    .LenWidth     (8),
    .NestLenWidth (NestLenWidth)
  ) u_affine_cnt (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .load_i        (r_req_ready && req_valid_i && (w_req_mode == MODE_AFFINE)),
    .advance_i     (w_cnt_advance),
    .base_i        (req_addr_i),
    .stride_i      (r_stride_b),
    .nest_stride_i (r_nest_stride_b),
    .len_i         (r_len),
    .nest_len_i    (r_nest_len),
    .next_addr_o   (w_cnt_next_addr),
    .next_last_o   (w_cnt_next_last)
`ifdef AXI_PACK_AG_OVF_CHK_EN
    ,
    .carry_o       (w_cnt_carry)
`endif
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= ST_IDLE;
      r_req_ready     <= 1'b1;
      r_addr_valid    <= 1'b0;
      r_addr          <= '0;
      r_last          <= 1'b0;
      r_len           <= '0;
      r_nest_len      <= '0;
      r_stride_b      <= '0;
      r_nest_stride_b <= '0;
      r_size          <= '0;
      r_idx_size      <= '0;
      r_ind_base      <= '0;
      r_remaining     <= '0;
`ifdef AXI_PACK_AG_OVF_CHK_EN
      r_err           <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid_i) begin
          r_req_ready     <= 1'b0;
          r_len           <= req_len_i;
          r_nest_len      <= req_nest_len_i;
          r_stride_b      <= AddrWidth'(req_stride_i) << req_size_i;
          r_nest_stride_b <= AddrWidth'(req_nest_stride_i) << req_size_i;
          r_size          <= req_size_i;
          r_idx_size      <= req_index_size_i;
          if (w_req_mode == MODE_INDIRECT) begin
            // Base+offset is folded once here so each index needs a single add.
            r_state     <= ST_INDIRECT;
            r_remaining <= {1'b0, req_len_i} + 9'd1;
            r_ind_base  <= w_ind_base_sum[AddrWidth-1:0];
`ifdef AXI_PACK_AG_OVF_CHK_EN
            if (w_ind_base_sum[AddrWidth]) r_err <= 1'b1;
`endif
          end else begin
            r_state      <= ST_AFFINE;
            r_addr_valid <= 1'b1;
            r_addr       <= req_addr_i;
            r_last       <= (req_len_i == '0) && (req_nest_len_i == '0);
          end
        end
        ST_AFFINE: if (w_addr_fire) begin
          if (r_last) begin
            r_state      <= ST_IDLE;
            r_addr_valid <= 1'b0;
            r_last       <= 1'b0;
            r_req_ready  <= 1'b1;
          end else begin
            r_addr <= w_cnt_next_addr;
            r_last <= w_cnt_next_last;
`ifdef AXI_PACK_AG_OVF_CHK_EN
            if (w_cnt_carry) r_err <= 1'b1;
`endif
          end
        end
        ST_INDIRECT: begin
          if (w_idx_fire) begin
            r_addr_valid <= 1'b1;
            r_addr       <= w_ind_sum[AddrWidth-1:0];
            r_last       <= (r_remaining == 9'd1);
            r_remaining  <= r_remaining - 9'd1;
`ifdef AXI_PACK_AG_OVF_CHK_EN
            if (w_ind_sum[AddrWidth]) r_err <= 1'b1;
`endif
          end else if (w_addr_fire) begin
            r_addr_valid <= 1'b0;
            if (r_last) begin
              r_state     <= ST_IDLE;
              r_last      <= 1'b0;
              r_req_ready <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o  = r_req_ready;
  assign idx_ready_o  = w_idx_ready;
  assign addr_valid_o = r_addr_valid;
  assign addr_o       = r_addr;
  assign addr_last_o  = r_last;
  assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axi_pack_addr_gen.sv
// Randomised bench for axi_pack_addr_gen against a queue-based address model.
// Checks err_o as well when AXI_PACK_AG_OVF_CHK_EN is defined.
module tb_axi_pack_addr_gen;

  localparam int unsigned AW = 48;

  typedef struct {
    longint unsigned base;
    int unsigned     size;
    int unsigned     len;
    bit              indirect;
    int unsigned     stride;
    int unsigned     nest_len;
    int unsigned     nest_stride;
    int unsigned     idx_size;
    int unsigned     offset;
  } req_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic [1:0]    req_size_i;
  logic [7:0]    req_len_i;
  logic          req_indirect_i;
  logic [7:0]    req_stride_i;
  logic [5:0]    req_nest_len_i;
  logic [5:0]    req_nest_stride_i;
  logic [2:0]    req_index_size_i;
  logic [16:0]   req_index_offset_i;
  logic          idx_valid_i;
  logic          idx_ready_o;
  logic [31:0]   idx_data_i;
  logic          addr_valid_o;
  logic          addr_ready_i;
  logic [AW-1:0] addr_o;
  logic          addr_last_o;
  logic          busy_o;
`ifdef AXI_PACK_AG_OVF_CHK_EN
  logic          err_o;
`endif

  always #5 clk_i = ~clk_i;

  axi_pack_addr_gen #(.AddrWidth(AW)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_addr_i         (req_addr_i),
    .req_size_i         (req_size_i),
    .req_len_i          (req_len_i),
    .req_indirect_i     (req_indirect_i),
    .req_stride_i       (req_stride_i),
    .req_nest_len_i     (req_nest_len_i),
    .req_nest_stride_i  (req_nest_stride_i),
    .req_index_size_i   (req_index_size_i),
    .req_index_offset_i (req_index_offset_i),
    .idx_valid_i        (idx_valid_i),
    .idx_ready_o        (idx_ready_o),
    .idx_data_i         (idx_data_i),
    .addr_valid_o       (addr_valid_o),
    .addr_ready_i       (addr_ready_i),
    .addr_o             (addr_o),
    .addr_last_o        (addr_last_o),
    .busy_o             (busy_o)
`ifdef AXI_PACK_AG_OVF_CHK_EN
    ,
    .err_o              (err_o)
`endif
  );

  int unsigned     n_cmp = 0;
  int unsigned     n_err = 0;
  longint unsigned exp_q[$];
  logic [31:0]     idx_q[$];
  bit              exp_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected true (unwrapped) addresses straight from the request definition.
  task automatic build_model(input req_t r);
    longint unsigned m, bits;
    exp_q.delete();
    if (!r.indirect) begin
      for (longint unsigned j = 0; j <= r.nest_len; j++)
        for (longint unsigned i = 0; i <= r.len; i++)
          exp_q.push_back(r.base + j * (longint'(r.nest_stride) << r.size)
                                 + i * (longint'(r.stride) << r.size));
    end else begin
      bits = 64'd8 << r.idx_size;
      for (int k = 0; k <= int'(r.len); k++) begin
        m = (bits >= 32) ? longint'(idx_q[k]) : (longint'(idx_q[k]) % (64'd1 << bits));
        exp_q.push_back(r.base + r.offset + (m << r.size));
      end
    end
  endtask

  task automatic run_req(input req_t r, input int rdy_pct, input int ivld_pct,
                         input int stall_at, input int abort_after);
    int              k_idx = 0;
    int              n_hs = 0;
    int              stall_left = 0;
    bit              stalled = 1'b0;
    logic [AW-1:0]   prev_addr = '0;
    logic            prev_last = 1'b0;
    longint unsigned e;
    build_model(r);
    @(negedge clk_i);
    req_addr_i         = r.base[AW-1:0];
    req_size_i         = 2'(r.size);
    req_len_i          = 8'(r.len);
    req_indirect_i     = r.indirect;
    req_stride_i       = 8'(r.stride);
    req_nest_len_i     = 6'(r.nest_len);
    req_nest_stride_i  = 6'(r.nest_stride);
    req_index_size_i   = 3'(r.idx_size);
    req_index_offset_i = 17'(r.offset);
    req_valid_i        = 1'b1;
    addr_ready_i       = 1'b0;
    #1 check("req_ready_idle", req_ready_o, 1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check("req_ready_busy", req_ready_o, 0);
    check("busy_accept", busy_o, 1);
    for (int cyc = 0; cyc < 4000 && exp_q.size() > 0; cyc++) begin
      if (abort_after >= 0 && n_hs == abort_after) return;
      if (stalled) begin
        check("hold_valid", addr_valid_o, 1);
        check("hold_addr", addr_o, prev_addr);
        check("hold_last", addr_last_o, prev_last);
      end
      if (stall_left > 0) begin
        addr_ready_i = 1'b0;
        stall_left--;
      end else addr_ready_i = ($urandom_range(99) < rdy_pct);
      idx_valid_i = r.indirect && (k_idx < idx_q.size()) && ($urandom_range(99) < ivld_pct);
      idx_data_i  = idx_valid_i ? idx_q[k_idx] : $urandom;
      #1;
      if (r.indirect && addr_valid_o && !addr_ready_i) check("idx_ready_held", idx_ready_o, 0);
      if (idx_valid_i && idx_ready_o) k_idx++;
      if (addr_valid_o && addr_ready_i) begin
        e = exp_q.pop_front();
        check("addr", addr_o, e[AW-1:0]);
        check("last", addr_last_o, exp_q.size() == 0);
        if ((e >> AW) != 0) exp_err = 1'b1;
        n_hs++;
        if (n_hs == stall_at) stall_left = 5;
      end
      stalled   = addr_valid_o && !addr_ready_i;
      prev_addr = addr_o;
      prev_last = addr_last_o;
      @(negedge clk_i);
    end
    addr_ready_i = 1'b0;
    idx_valid_i  = 1'b0;
    check("timeout_remaining", exp_q.size(), 0);
    check("req_ready_done", req_ready_o, 1);
    check("busy_done", busy_o, 0);
    check("valid_done", addr_valid_o, 0);
`ifdef AXI_PACK_AG_OVF_CHK_EN
    check("err", err_o, exp_err);
`endif
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    addr_ready_i = 1'b0;
    idx_valid_i  = 1'b0;
    req_valid_i  = 1'b0;
    rst_i        = 1'b1;
    @(negedge clk_i);
    rst_i   = 1'b0;
    exp_err = 1'b0;
    exp_q.delete();
  endtask

  req_t r;

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; addr_ready_i = 1'b0; idx_valid_i = 1'b0;
    idx_data_i = '0; req_addr_i = '0; req_size_i = '0; req_len_i = '0;
    req_indirect_i = 1'b0; req_stride_i = '0; req_nest_len_i = '0;
    req_nest_stride_i = '0; req_index_size_i = '0; req_index_offset_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst_req_ready", req_ready_o, 1);
    check("rst_idx_ready", idx_ready_o, 0);
    check("rst_addr_valid", addr_valid_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_last", addr_last_o, 0);
    check("rst_busy", busy_o, 0);
`ifdef AXI_PACK_AG_OVF_CHK_EN
    check("rst_err", err_o, 0);
`endif

    r = '{base: 64'h1000, size: 2, len: 3, indirect: 0, stride: 1,
          nest_len: 0, nest_stride: 0, idx_size: 0, offset: 0};
    run_req(r, 100, 100, -1, -1);

    r = '{base: 64'h0, size: 0, len: 1, indirect: 0, stride: 2,
          nest_len: 2, nest_stride: 16, idx_size: 0, offset: 0};
    run_req(r, 100, 100, -1, -1);

    // Indices presented while idle must not be taken.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      idx_valid_i = 1'b1;
      idx_data_i  = 32'hDEAD;
      #1 check("idle_idx_ready", idx_ready_o, 0);
    end
    idx_valid_i = 1'b0;

    idx_q = '{32'h101, 32'h05, 32'hFF};
    r = '{base: 64'h2000, size: 3, len: 2, indirect: 1, stride: 0,
          nest_len: 0, nest_stride: 0, idx_size: 0, offset: 32'h10};
    run_req(r, 100, 100, -1, -1);

    r = '{base: 64'h3000, size: 1, len: 4, indirect: 0, stride: 3,
          nest_len: 1, nest_stride: 0, idx_size: 0, offset: 0};
    run_req(r, 100, 100, 2, -1);

    idx_q = '{32'h12345678, 32'h1, 32'hFFFF0002, 32'h7, 32'h80000000, 32'h3};
    r = '{base: 64'h4000, size: 2, len: 5, indirect: 1, stride: 0,
          nest_len: 0, nest_stride: 0, idx_size: 1, offset: 32'h1FFFF};
    run_req(r, 100, 100, 1, -1);

    r = '{base: 64'h5000, size: 2, len: 7, indirect: 0, stride: 1,
          nest_len: 3, nest_stride: 9, idx_size: 0, offset: 0};
    run_req(r, 100, 100, -1, 3);
    pulse_reset();
    #1;
    check("midrst_valid", addr_valid_o, 0);
    check("midrst_req_ready", req_ready_o, 1);
    check("midrst_busy", busy_o, 0);
    r = '{base: 64'h7700, size: 0, len: 2, indirect: 0, stride: 5,
          nest_len: 1, nest_stride: 1, idx_size: 0, offset: 0};
    run_req(r, 100, 100, -1, -1);

`ifdef AXI_PACK_AG_OVF_CHK_EN
    r = '{base: 64'hFFFF_FFFF_FFFC, size: 2, len: 1, indirect: 0, stride: 1,
          nest_len: 0, nest_stride: 0, idx_size: 0, offset: 0};
    run_req(r, 100, 100, -1, -1);
    r = '{base: 64'h100, size: 0, len: 1, indirect: 0, stride: 1,
          nest_len: 0, nest_stride: 0, idx_size: 0, offset: 0};
    run_req(r, 100, 100, -1, -1);
    pulse_reset();
    #1 check("err_cleared", err_o, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      r.indirect    = $urandom_range(1);
      r.base        = ($urandom_range(7) == 0) ? ((64'd1 << AW) - $urandom_range(256))
                                               : {16'($urandom), 32'($urandom)};
      r.size        = $urandom_range(3);
      r.len         = ($urandom_range(9) == 0) ? 0 : $urandom_range(15);
      r.stride      = ($urandom_range(5) == 0) ? 0 : $urandom_range(255);
      r.nest_len    = $urandom_range(5);
      r.nest_stride = $urandom_range(63);
      r.idx_size    = $urandom_range(7);
      r.offset      = $urandom_range(17'h1FFFF);
      idx_q.delete();
      for (int k = 0; k <= int'(r.len); k++) idx_q.push_back($urandom);
      run_req(r, $urandom_range(30, 100), $urandom_range(30, 100), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_pack_addr_gen.md
Name: axi_pack_addr_gen

Overview:
- Parametrised element-address generator for packed AXI streams; successor to the fixed-width SSR user-field definitions.
- Accepts one burst request (base, size, len, mode fields) and emits one element address per handshake.
- Two modes: affine with a two-level nest (stride + nest_len/nest_stride), or indirect (addresses from an index stream plus base offset).
- Sits between the SSR request decoder and the AXI pack beat builder.

Parameters:
- AddrWidth, 48, address width; arithmetic modulo 2^AddrWidth.
- StrideWidth, 8, affine inner stride width (elements).
- NestLenWidth, 6, nest_len width.
- NestStrideWidth, 6, nest_stride width (elements).
- IndexWidth, 32, index stream data width.
- IndexOffsetWidth, 17, indirect base offset width (bytes).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_addr_i  in  AddrWidth  base byte address.
- req_size_i  in  2  element size log2 (bytes).
- req_len_i  in  8  elements per row minus 1 (AXI semantic).
- req_indirect_i  in  1  1 = indirect mode.
- req_stride_i  in  StrideWidth  inner stride (elements).
- req_nest_len_i  in  NestLenWidth  rows minus 1.
- req_nest_stride_i  in  NestStrideWidth  row stride (elements).
- req_index_size_i  in  3  index width log2 (bytes).
- req_index_offset_i  in  IndexOffsetWidth  byte offset added in indirect mode.
- idx_valid_i  in  1  index valid.
- idx_ready_o  out  1  index ready.
- idx_data_i  in  IndexWidth  index value.
- addr_valid_o  out  1  address valid.
- addr_ready_i  in  1  address ready.
- addr_o  out  AddrWidth  element byte address.
- addr_last_o  out  1  final element of request.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE; req_ready_o=1, idx_ready_o=0, addr_valid_o=0, addr_o=0, addr_last_o=0, busy_o=0; all counters 0. Reset mid-request drops it, no further addresses.
- FSM IDLE/AFFINE/INDIRECT. req_ready_o=1 only in IDLE. Accept on req_valid_i&&req_ready_o; all fields latched.
- AFFINE:
  - First address registered, addr_valid_o asserted the cycle after acceptance.
  - Element (i,j), i=0..len, j=0..nest_len: addr = base + j*(nest_stride<<size) + i*(stride<<size), computed incrementally with adders (no multipliers).
  - Advance on addr handshake; i wraps to 0 and j increments when i==len.
  - Total (len+1)*(nest_len+1) addresses; stride 0 and nest_stride 0 are legal (repeated addresses).
- INDIRECT:
  - len+1 addresses. Index masked to low 8<<index_size bits; index_size >= log2(IndexWidth/8) uses the full word.
  - addr = base + offset + (masked_idx<<size).
  - One output register: idx_ready_o = state==INDIRECT && remaining>0 && (!addr_valid_o || addr_ready_i). Index accepted and previous address consumed in the same cycle gives full throughput.
  - Indices arriving in IDLE are not consumed.
- Output stability: addr_o/addr_last_o hold while addr_valid_o && !addr_ready_i. addr_last_o=1 only with the final element.
- Completion: final handshake returns to IDLE; req_ready_o=1 the next cycle. No same-cycle request overlap.
- Overflow wraps modulo 2^AddrWidth.

Optional Feature:
- AXI_PACK_AG_OVF_CHK_EN defined: adds port err_o (out, 1, sticky).
  - Set the cycle after any address add carries out of AddrWidth.
  - Cleared only by rst_i. Generation continues with the wrapped address.
- Undefined: port absent, no carry logic.

Decomposition:
- axi_pack_pkg gains parametrised type helpers and constants: mode enum (AFFINE/INDIRECT), FSM state enum, default width constants (StrideWidth=8, NestLenWidth=6, NestStrideWidth=6, IndexOffsetWidth=17).
- Existing affine_t/indirect_t/ssr_user_t remain as default-width instances.
- One sub-module: axi_pack_affine_cnt (two-level nested counter with row-base/element-address accumulators, last flag).

Test Plan:
- Affine, base=0x1000, size=2, len=3, stride=1, nest_len=0, addr_ready_i=1 -> 0x1000,0x1004,0x1008,0x100C; last on 4th; req_ready_o=1 next cycle.
- Affine, base=0x0, size=0, len=1, stride=2, nest_len=2, nest_stride=16 -> 0,2,16,18,32,34; last on 34.
- Indirect, base=0x2000, offset=0x10, size=3, index_size=0, len=2, idx=0x101,0x05,0xFF -> 0x2018 (masked to 0x01),0x2038,0x2808.
- Backpressure: addr_ready_i low 5 cycles mid-burst -> addr_o stable; in indirect mode idx_ready_o=0 while output held; no address lost or duplicated.
- rst_i pulsed mid-affine burst -> next cycle addr_valid_o=0, req_ready_o=1; next request starts from its own base.
- AXI_PACK_AG_OVF_CHK_EN, AddrWidth=16, base=0xFFFC, size=2, stride=1, len=1 -> 0xFFFC,0x0000; err_o=1 and sticky until rst_i.
